// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the bus masters and the round-robin arbiter.
// The arbiter connects through the slave modport; the master side drives requests and strobe.
interface bus_arbiter_rr_if;
    logic       bus_m0_req;
    logic       bus_m1_req;
    logic       bus_m2_req;
    logic       bus_m3_req;
    logic       bus_as;
    logic       bus_m0_grnt;
    logic       bus_m1_grnt;
    logic       bus_m2_grnt;
    logic       bus_m3_grnt;
    logic [1:0] arb_owner;
    logic       arb_busy;
    logic       arb_preempt;

    modport master (
        output bus_m0_req, bus_m1_req, bus_m2_req, bus_m3_req, bus_as,
        input  bus_m0_grnt, bus_m1_grnt, bus_m2_grnt, bus_m3_grnt,
        input  arb_owner, arb_busy, arb_preempt
    );

    modport slave (
        input  bus_m0_req, bus_m1_req, bus_m2_req, bus_m3_req, bus_as,
        output bus_m0_grnt, bus_m1_grnt, bus_m2_grnt, bus_m3_grnt,
        output arb_owner, arb_busy, arb_preempt
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with tenure-based preemption at transfer boundaries.
// Grants are held for the whole tenure; a forced release inserts a one-cycle gap.
module bus_arbiter_rr #(
    parameter int TENURE_W   = 8,
    parameter int MAX_TENURE = 16
) (
    input  logic            clk,
    input  logic            rest,
    bus_arbiter_rr_if.slave bus
);

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    localparam logic                PRE_EN = (MAX_TENURE != 0);
    localparam logic [TENURE_W-1:0] MAX_T  = TENURE_W'(MAX_TENURE);
    localparam logic [TENURE_W-1:0] PRE_T  = TENURE_W'((MAX_TENURE == 0) ? 0 : MAX_TENURE - 1);

    state_t              state;
    logic [3:0]          grnt;
    logic [1:0]          owner;
    logic [1:0]          last;
    logic [TENURE_W-1:0] tenure;
    logic                preempt;
    logic                busy;

    logic [3:0] req;
    logic [3:0] others;
    logic [1:0] pick_idle;
    logic [1:0] pick_own;
    logic       do_preempt;

    // Search starts one past base and wraps, so base itself has lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign req        = {bus.bus_m3_req, bus.bus_m2_req, bus.bus_m1_req, bus.bus_m0_req};
    assign others     = req & ~onehot(owner);
    assign pick_idle  = rr_pick(req, last);
    assign pick_own   = rr_pick(others, owner);
    assign do_preempt = PRE_EN && (tenure >= PRE_T) && (|others) && !bus.bus_as;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state   <= IDLE;
            grnt    <= 4'b0000;
            owner   <= 2'd0;
            last    <= 2'd3;
            tenure  <= '0;
            preempt <= 1'b0;
            busy    <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (|req) begin
                        grnt   <= onehot(pick_idle);
                        owner  <= pick_idle;
                        last   <= pick_idle;
                        tenure <= '0;
                        busy   <= 1'b1;
                        state  <= OWN;
                    end else begin
                        grnt  <= 4'b0000;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                OWN: begin
                    if (!req[owner]) begin
                        if (|others) begin
                            grnt   <= onehot(pick_own);
                            owner  <= pick_own;
                            last   <= pick_own;
                            tenure <= '0;
                            busy   <= 1'b1;
                        end else begin
                            grnt  <= 4'b0000;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (do_preempt) begin
                        // Release only between transfers; the owner drops to lowest priority.
                        grnt    <= 4'b0000;
                        busy    <= 1'b0;
                        tenure  <= '0;
                        preempt <= 1'b1;
                        state   <= GAP;
                    end else if (tenure < MAX_T) begin
                        tenure <= tenure + 1'b1;
                    end
                end
                default: begin
                    grnt  <= 4'b0000;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.bus_m0_grnt = grnt[0];
    assign bus.bus_m1_grnt = grnt[1];
    assign bus.bus_m2_grnt = grnt[2];
    assign bus.bus_m3_grnt = grnt[3];
    assign bus.arb_owner   = owner;
    assign bus.arb_busy    = busy;
    assign bus.arb_preempt = preempt;

endmodule
